// File: rtl/pcie_rx_tlp_decoder_if.sv
// PCIe RX TLP decoder bus: AXI-stream dwords in, decoded header and
// payload stream out. slave = decoder side, master = bridge/consumer side.
interface pcie_rx_tlp_decoder_if;
    logic [31:0] m_axis_rx_tdata;
    logic [3:0]  m_axis_rx_tkeep;
    logic        m_axis_rx_tlast;
    logic        m_axis_rx_tvalid;
    logic        m_axis_rx_tready;
    logic [21:0] m_axis_rx_tuser;
    logic        rx_np_ok;
    logic        o_hdr_stb;
    logic [1:0]  o_kind;
    logic [10:0] o_length;
    logic [15:0] o_req_id;
    logic [7:0]  o_tag;
    logic [7:0]  o_be;
    logic [31:0] o_addr;
    logic [31:0] o_hdr_dw1;
    logic [31:0] o_data;
    logic        o_data_valid;
    logic        o_data_last;
    logic        i_data_ready;
    logic        o_tlp_err;
    logic [1:0]  o_err_code;

    modport slave (
        input  m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast,
        input  m_axis_rx_tvalid, m_axis_rx_tuser, i_data_ready,
        output m_axis_rx_tready, rx_np_ok, o_hdr_stb, o_kind, o_length,
        output o_req_id, o_tag, o_be, o_addr, o_hdr_dw1,
        output o_data, o_data_valid, o_data_last, o_tlp_err, o_err_code
    );

    modport master (
        output m_axis_rx_tdata, m_axis_rx_tkeep, m_axis_rx_tlast,
        output m_axis_rx_tvalid, m_axis_rx_tuser, i_data_ready,
        input  m_axis_rx_tready, rx_np_ok, o_hdr_stb, o_kind, o_length,
        input  o_req_id, o_tag, o_be, o_addr, o_hdr_dw1,
        input  o_data, o_data_valid, o_data_last, o_tlp_err, o_err_code
    );
endinterface

// File: rtl/pcie_rx_tlp_decoder.sv
// RX TLP decoder: parses MRd/MWr/Cpl/CplD headers from a 32-bit dword
// stream, forwards payload through a one-deep output register.
module pcie_rx_tlp_decoder #(
    parameter int unsigned MAX_PAYLOAD_DW = 128
) (
    input  logic clk,
    input  logic rst,
    pcie_rx_tlp_decoder_if.slave rx
);
    typedef enum logic [2:0] {HDR0, HDR1, HDR2, HDR3, DATA, DROP} state_t;

    localparam logic [11:0] MAX_LEN = 12'(MAX_PAYLOAD_DW);

    state_t      state_q, state_d;
    logic [1:0]  fmt_q, fmt_d;
    logic        cpl_q, cpl_d;
    logic [10:0] len_q, len_d;
    logic [31:0] dw1_q, dw1_d;
    logic [10:0] cnt_q, cnt_d;
    logic        stb_q, stb_d;
    logic [1:0]  kind_q, kind_d;
    logic [10:0] olen_q, olen_d;
    logic [31:0] hdw1_q, hdw1_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        dv_q, dv_d;
    logic        dl_q, dl_d;
    logic        err_q, err_d;
    logic [1:0]  ecode_q, ecode_d;

    logic        tready, xfer, last, poison, sup, fin4;
    logic [31:0] dw;
    logic [10:0] dlen;
    logic        unused_in;

    assign unused_in = ^{rx.m_axis_rx_tkeep, rx.m_axis_rx_tuser[21:2],
                         rx.m_axis_rx_tuser[0]};

    assign dw     = rx.m_axis_rx_tdata;
    assign last   = rx.m_axis_rx_tlast;
    assign poison = rx.m_axis_rx_tuser[1];
    assign tready = (state_q == DATA) ? (!dv_q || rx.i_data_ready) : 1'b1;
    assign xfer   = rx.m_axis_rx_tvalid && tready;
    assign dlen   = (dw[9:0] == 10'd0) ? 11'd1024 : {1'b0, dw[9:0]};
    assign sup    = (dw[28:24] == 5'b00000) ||
                    ((dw[28:24] == 5'b01010) && !dw[29]);
    assign fin4   = (state_q == HDR2) && fmt_q[0];

    always_comb begin
        state_d = state_q;
        fmt_d   = fmt_q;
        cpl_d   = cpl_q;
        len_d   = len_q;
        dw1_d   = dw1_q;
        cnt_d   = cnt_q;
        stb_d   = 1'b0;
        kind_d  = kind_q;
        olen_d  = olen_q;
        hdw1_d  = hdw1_q;
        addr_d  = addr_q;
        data_d  = data_q;
        dv_d    = dv_q;
        dl_d    = dl_q;
        err_d   = 1'b0;
        ecode_d = ecode_q;
        if (dv_q && rx.i_data_ready) begin
            dv_d = 1'b0;
            dl_d = 1'b0;
        end
        if (xfer) begin
            if (state_q != DROP && poison) begin
                err_d   = 1'b1;
                ecode_d = 2'd3;
                state_d = last ? HDR0 : DROP;
            end else begin
                unique case (state_q)
                    HDR0: begin
                        fmt_d = dw[30:29];
                        cpl_d = dw[27];
                        len_d = dlen;
                        if (!sup) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd1;
                            state_d = last ? HDR0 : DROP;
                        end else if (last) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd2;
                            state_d = HDR0;
                        end else begin
                            state_d = HDR1;
                        end
                    end
                    HDR1: begin
                        dw1_d = dw;
                        if (last) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd2;
                            state_d = HDR0;
                        end else begin
                            state_d = HDR2;
                        end
                    end
                    HDR2, HDR3: begin
                        if (fin4) begin
                            // upper address of a 4DW header is dropped
                            if (last) begin
                                err_d   = 1'b1;
                                ecode_d = 2'd2;
                                state_d = HDR0;
                            end else begin
                                state_d = HDR3;
                            end
                        end else if (fmt_q[1] && ({1'b0, len_q} > MAX_LEN)) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd3;
                            state_d = last ? HDR0 : DROP;
                        end else if (fmt_q[1] && last) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd2;
                            state_d = HDR0;
                        end else begin
                            stb_d   = 1'b1;
                            kind_d  = {cpl_q, fmt_q[1]};
                            olen_d  = len_q;
                            hdw1_d  = dw1_q;
                            addr_d  = cpl_q ? dw : {dw[31:2], 2'b00};
                            cnt_d   = len_q;
                            state_d = fmt_q[1] ? DATA : HDR0;
                        end
                    end
                    DATA: begin
                        data_d = dw;
                        dv_d   = 1'b1;
                        dl_d   = last || (cnt_q == 11'd1);
                        cnt_d  = cnt_q - 11'd1;
                        if (cnt_q == 11'd1) begin
                            state_d = last ? HDR0 : DROP;
                            err_d   = !last;
                            ecode_d = last ? ecode_q : 2'd3;
                        end else if (last) begin
                            err_d   = 1'b1;
                            ecode_d = 2'd2;
                            state_d = HDR0;
                        end
                    end
                    DROP: begin
                        if (last) state_d = HDR0;
                    end
                    default: state_d = HDR0;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= HDR0;
            fmt_q   <= '0;
            cpl_q   <= 1'b0;
            len_q   <= '0;
            dw1_q   <= '0;
            cnt_q   <= '0;
            stb_q   <= 1'b0;
            kind_q  <= '0;
            olen_q  <= '0;
            hdw1_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            dl_q    <= 1'b0;
            err_q   <= 1'b0;
            ecode_q <= '0;
        end else begin
            state_q <= state_d;
            fmt_q   <= fmt_d;
            cpl_q   <= cpl_d;
            len_q   <= len_d;
            dw1_q   <= dw1_d;
            cnt_q   <= cnt_d;
            stb_q   <= stb_d;
            kind_q  <= kind_d;
            olen_q  <= olen_d;
            hdw1_q  <= hdw1_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            dl_q    <= dl_d;
            err_q   <= err_d;
            ecode_q <= ecode_d;
        end
    end

    assign rx.m_axis_rx_tready = tready && !rst;
    assign rx.rx_np_ok     = !(dv_q && !rx.i_data_ready);
    assign rx.o_hdr_stb    = stb_q;
    assign rx.o_kind       = kind_q;
    assign rx.o_length     = olen_q;
    assign rx.o_hdr_dw1    = hdw1_q;
    assign rx.o_req_id     = hdw1_q[31:16];
    assign rx.o_tag        = hdw1_q[15:8];
    assign rx.o_be         = hdw1_q[7:0];
    assign rx.o_addr       = addr_q;
    assign rx.o_data       = data_q;
    assign rx.o_data_valid = dv_q;
    assign rx.o_data_last  = dl_q;
    assign rx.o_tlp_err    = err_q;
    assign rx.o_err_code   = ecode_q;
endmodule

// File: tb/tb_pcie_rx_tlp_decoder.sv
// Directed bench for pcie_rx_tlp_decoder: header decode, payload,
// error paths, backpressure and mid-TLP reset.
module tb_pcie_rx_tlp_decoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    pcie_rx_tlp_decoder_if bus ();

    pcie_rx_tlp_decoder #(.MAX_PAYLOAD_DW(128)) dut (
        .clk(clk),
        .rst(rst),
        .rx (bus.slave)
    );

    always #5 clk = ~clk;

    int          hdr_n = 0;
    int          err_n = 0;
    logic [1:0]  last_err = '0;
    logic [1:0]  h_kind;
    logic [10:0] h_len;
    logic [15:0] h_req;
    logic [7:0]  h_tag, h_be;
    logic [31:0] h_addr;
    logic [32:0] md[$];

    always @(negedge clk) begin
        if (bus.o_hdr_stb) begin
            hdr_n++;
            h_kind = bus.o_kind;
            h_len  = bus.o_length;
            h_req  = bus.o_req_id;
            h_tag  = bus.o_tag;
            h_be   = bus.o_be;
            h_addr = bus.o_addr;
        end
        if (bus.o_tlp_err) begin
            err_n++;
            last_err = bus.o_err_code;
        end
        if (bus.o_data_valid && bus.i_data_ready)
            md.push_back({bus.o_data_last, bus.o_data});
    end

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] d, input logic l,
                        input logic poi = 1'b0);
        bit done = 0;
        bus.m_axis_rx_tdata  = d;
        bus.m_axis_rx_tlast  = l;
        bus.m_axis_rx_tuser  = poi ? 22'd2 : 22'd0;
        bus.m_axis_rx_tvalid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            if (bus.m_axis_rx_tready) begin
                @(posedge clk);
                #1;
                done = 1;
            end
        end
        if (!done) chk("push_timeout", 0, 1);
        bus.m_axis_rx_tvalid = 1'b0;
        bus.m_axis_rx_tlast  = 1'b0;
        bus.m_axis_rx_tuser  = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    int hb, eb, db;

    task automatic snap();
        hb = hdr_n;
        eb = err_n;
        db = md.size();
    endtask

    initial begin
        bus.m_axis_rx_tdata  = '0;
        bus.m_axis_rx_tkeep  = 4'hF;
        bus.m_axis_rx_tlast  = 1'b0;
        bus.m_axis_rx_tvalid = 1'b0;
        bus.m_axis_rx_tuser  = '0;
        bus.i_data_ready     = 1'b1;

        @(negedge clk);
        chk("rst_tready", bus.m_axis_rx_tready, 0);
        chk("rst_npok", bus.rx_np_ok, 1);
        chk("rst_stb", bus.o_hdr_stb, 0);
        chk("rst_dv", bus.o_data_valid, 0);
        chk("rst_addr", bus.o_addr, 0);
        chk("rst_err", bus.o_tlp_err, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // MWr 3DW
        snap();
        push(32'h4000_0002, 0);
        push(32'h00AB_01FF, 0);
        push(32'h0000_1004, 0);
        push(32'h0000_0011, 0);
        push(32'h0000_0022, 1);
        idle(4);
        chk("mwr_hdr", hdr_n - hb, 1);
        chk("mwr_kind", h_kind, 1);
        chk("mwr_len", h_len, 2);
        chk("mwr_req", h_req, 16'h00AB);
        chk("mwr_tag", h_tag, 8'h01);
        chk("mwr_be", h_be, 8'hFF);
        chk("mwr_addr", h_addr, 32'h1004);
        chk("mwr_ndata", md.size() - db, 2);
        chk("mwr_d0", md[db], {1'b0, 32'h11});
        chk("mwr_d1", md[db+1], {1'b1, 32'h22});
        chk("mwr_noerr", err_n - eb, 0);

        // MRd 4DW, low address bits forced to 0
        snap();
        push(32'h2000_0001, 0);
        push(32'h1234_5A0F, 0);
        push(32'h0000_0001, 0);
        push(32'hC000_0003, 1);
        idle(4);
        chk("mrd_hdr", hdr_n - hb, 1);
        chk("mrd_kind", h_kind, 0);
        chk("mrd_len", h_len, 1);
        chk("mrd_req", h_req, 16'h1234);
        chk("mrd_tag", h_tag, 8'h5A);
        chk("mrd_be", h_be, 8'h0F);
        chk("mrd_addr", h_addr, 32'hC000_0000);
        chk("mrd_ndata", md.size() - db, 0);

        // oversize MWr dropped, next Cpl decodes
        snap();
        push(32'h4000_0200, 0);
        push(32'h0001_0000, 0);
        push(32'h0000_2000, 0);
        push(32'h0000_0001, 0);
        push(32'h0000_0002, 0);
        push(32'h0000_0003, 1);
        idle(3);
        chk("ovs_hdr", hdr_n - hb, 0);
        chk("ovs_err", err_n - eb, 1);
        chk("ovs_code", last_err, 3);
        chk("ovs_ndata", md.size() - db, 0);
        snap();
        push(32'h0A00_0001, 0);
        push(32'hBEEF_0700, 0);
        push(32'hCAFE_F00D, 1);
        idle(3);
        chk("cpl_hdr", hdr_n - hb, 1);
        chk("cpl_kind", h_kind, 2);
        chk("cpl_addr", h_addr, 32'hCAFE_F00D);
        chk("cpl_req", h_req, 16'hBEEF);

        // CplD len 4 ending after 2 dwords
        snap();
        push(32'h4A00_0004, 0);
        push(32'h0010_0000, 0);
        push(32'h0001_0203, 0);
        push(32'h0000_00A1, 0);
        push(32'h0000_00A2, 1);
        idle(4);
        chk("cpld_kind", h_kind, 3);
        chk("cpld_len", h_len, 4);
        chk("cpld_ndata", md.size() - db, 2);
        chk("cpld_d0", md[db], {1'b0, 32'hA1});
        chk("cpld_d1", md[db+1], {1'b1, 32'hA2});
        chk("cpld_err", err_n - eb, 1);
        chk("cpld_code", last_err, 2);

        // unsupported type
        snap();
        push(32'h0400_0001, 0);
        push(32'h0000_0000, 0);
        push(32'h0000_0000, 1);
        idle(3);
        chk("uns_hdr", hdr_n - hb, 0);
        chk("uns_err", err_n - eb, 1);
        chk("uns_code", last_err, 1);

        // poisoned final payload dword
        snap();
        push(32'h4000_0002, 0);
        push(32'h0000_0000, 0);
        push(32'h0000_0040, 0);
        push(32'h0000_0001, 0);
        push(32'h0000_0002, 1, 1);
        idle(3);
        chk("poi_ndata", md.size() - db, 1);
        chk("poi_d0", md[db], {1'b0, 32'h1});
        chk("poi_err", err_n - eb, 1);
        chk("poi_code", last_err, 3);

        // backpressure for 5 cycles mid-payload
        snap();
        push(32'h4000_0003, 0);
        push(32'h0000_0000, 0);
        push(32'h0000_0100, 0);
        push(32'h0000_00D1, 0);
        bus.i_data_ready = 1'b0;
        fork
            begin
                push(32'h0000_00D2, 0);
                push(32'h0000_00D3, 1);
            end
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("stl_data", bus.o_data, 32'hD1);
                    chk("stl_dv", bus.o_data_valid, 1);
                    chk("stl_tready", bus.m_axis_rx_tready, 0);
                    chk("stl_npok", bus.rx_np_ok, 0);
                end
                @(posedge clk);
                #1 bus.i_data_ready = 1'b1;
            end
        join
        idle(4);
        chk("stl_ndata", md.size() - db, 3);
        chk("stl_d0", md[db], {1'b0, 32'hD1});
        chk("stl_d1", md[db+1], {1'b0, 32'hD2});
        chk("stl_d2", md[db+2], {1'b1, 32'hD3});

        // reset mid-payload
        push(32'h4000_0004, 0);
        push(32'h0000_0000, 0);
        push(32'h0000_0200, 0);
        push(32'h0000_0005, 0);
        push(32'h0000_0006, 0);
        #2 rst = 1'b1;
        #1;
        chk("mrst_dv", bus.o_data_valid, 0);
        chk("mrst_data", bus.o_data, 0);
        chk("mrst_addr", bus.o_addr, 0);
        chk("mrst_len", bus.o_length, 0);
        chk("mrst_tready", bus.m_axis_rx_tready, 0);
        chk("mrst_npok", bus.rx_np_ok, 1);
        idle(2);
        rst = 1'b0;
        idle(1);
        snap();
        push(32'h4000_0001, 0);
        push(32'h0055_0210, 0);
        push(32'h0000_ABC8, 0);
        push(32'h0000_0077, 1);
        idle(4);
        chk("post_hdr", hdr_n - hb, 1);
        chk("post_kind", h_kind, 1);
        chk("post_req", h_req, 16'h0055);
        chk("post_tag", h_tag, 8'h02);
        chk("post_be", h_be, 8'h10);
        chk("post_addr", h_addr, 32'hABC8);
        chk("post_ndata", md.size() - db, 1);
        chk("post_d0", md[db], {1'b1, 32'h77});
        chk("post_err", err_n - eb, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/pcie_rx_tlp_decoder.md
PCIE_RX_TLP_DECODER -- requirements
Module: pcie_rx_tlp_decoder

Interface
REQ-001 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-002 The block SHALL have parameter MAX_PAYLOAD_DW, default 128: the largest accepted payload length in dwords.
REQ-003 The block SHALL have these ports:
- clk  in  1  user clock from the PCIe AXI bridge
- rst  in  1  asynchronous active-high reset
- m_axis_rx_tdata  in  32  RX TLP dword stream
- m_axis_rx_tkeep  in  4  ignored; all dwords are treated as full
- m_axis_rx_tlast  in  1  last dword of the TLP
- m_axis_rx_tvalid  in  1  dword valid
- m_axis_rx_tready  out  1  decoder accepts the dword
- m_axis_rx_tuser  in  22  bit 1 = error-forward (poisoned)
- rx_np_ok  out  1  non-posted receive permitted
- o_hdr_stb  out  1  one-cycle pulse: decoded header fields are valid
- o_kind  out  2  0 MRd, 1 MWr, 2 Cpl, 3 CplD
- o_length  out  11  payload length in dwords, 1..1024
- o_req_id  out  16  DW1[31:16]
- o_tag  out  8  DW1[15:8]
- o_be  out  8  DW1[7:0]; last BE in [7:4], first BE in [3:0]
- o_addr  out  32  mem: low address, bits [1:0] forced to 0; cpl: raw DW2
- o_hdr_dw1  out  32  raw DW1
- o_data  out  32  payload dword
- o_data_valid  out  1  payload dword valid
- o_data_last  out  1  final payload dword
- i_data_ready  in  1  downstream accepts payload
- o_tlp_err  out  1  one-cycle error pulse
- o_err_code  out  2  1 unsupported, 2 early tlast, 3 oversize/late tlast/poisoned

Function
REQ-004 A dword SHALL transfer only when m_axis_rx_tvalid && m_axis_rx_tready are both high.
REQ-005 FSM states SHALL be HDR0, HDR1, HDR2, HDR3, DATA and DROP.
REQ-006 In HDR0 through HDR3, m_axis_rx_tready SHALL be 1.
REQ-007 In DATA, m_axis_rx_tready SHALL equal i_data_ready, or 1 if o_data_valid is low; in DROP it SHALL be 1.
REQ-008 HDR0 SHALL capture fmt = DW0[30:29], type = DW0[28:24] and len = DW0[9:0]; len 0 SHALL decode as 1024.
REQ-009 Supported TLPs SHALL be: type 00000 with fmt 00/01 (MRd) or 10/11 (MWr); type 01010 with fmt 00 (Cpl) or 10 (CplD).
- Any other TLP: go to DROP, pulse err code 1.
REQ-010 HDR1 SHALL capture DW1 into o_req_id, o_tag, o_be and o_hdr_dw1.
REQ-011 Address capture SHALL follow fmt[0]:
- fmt[0]=0 (3DW): HDR2 captures o_addr.
- fmt[0]=1 (4DW): HDR2 upper address is discarded; HDR3 captures o_addr.
REQ-012 o_hdr_stb SHALL pulse in the cycle after the final header dword transfers, with all o_* header fields stable until the next pulse.
REQ-013 After the final header dword, the FSM SHALL go to DATA if fmt[1]=1, else to HDR0.
REQ-014 A header with fmt[1]=1 and length > MAX_PAYLOAD_DW SHALL suppress o_hdr_stb, enter DROP, and pulse err code 3.
REQ-015 DATA SHALL use an 11-bit down-counter loaded with the length.
- o_data is registered; latency is 1 cycle from input transfer to o_data_valid.
- o_data, o_data_valid and o_data_last SHALL hold while i_data_ready is low.
REQ-016 When the counter reaches 1 with tlast high, o_data_last SHALL be 1 and the FSM SHALL return to HDR0.
REQ-017 When the counter reaches 1 without tlast, the dword SHALL be forwarded with o_data_last=1, the FSM SHALL enter DROP, and err code 3 SHALL pulse.
REQ-018 tlast with counter > 1 SHALL forward the dword with o_data_last=1, pulse err code 2, and return to HDR0.
REQ-019 tlast during HDR0 through HDR2 before header completion SHALL discard the TLP, pulse err code 2, and return to HDR0.
REQ-020 DROP SHALL discard dwords until tlast transfers, then return to HDR0.
REQ-021 m_axis_rx_tuser[1] high on any dword SHALL cause err code 3 and DROP for the rest of the TLP; payload already forwarded is not recalled.
REQ-022 rx_np_ok SHALL be 1 except when o_data_valid && !i_data_ready.

Reset
REQ-023 On rst, the FSM SHALL enter HDR0 immediately, regardless of mid-TLP state.
REQ-024 On rst, all outputs SHALL be 0 except rx_np_ok, which SHALL be 1.
REQ-025 After rst is released, the first dword transferred SHALL be treated as DW0.

Verification
REQ-026 MWr 3DW: 0x40000002, 0x00AB01FF, 0x00001004, 0x11, 0x22 (tlast) -> o_hdr_stb with kind 1, length 2, req_id 0x00AB, tag 0x01, be 0xFF, addr 0x00001004; o_data 0x11 then 0x22 with last.
REQ-027 MRd 4DW: 0x20000001, id/tag DW, 0x00000001, 0xC0000000 (tlast) -> kind 0, length 1, addr 0xC0000000, no payload.
REQ-028 MWr with length 0x200 and MAX_PAYLOAD_DW=128 -> no o_hdr_stb, err 3, all dwords consumed, next TLP decodes.
REQ-029 CplD length 4 with tlast on dword 2 -> two payload dwords, the second with last; err 2 pulse.
REQ-030 i_data_ready held low for 5 cycles mid-payload -> o_data stable, tready low, no dword lost.
REQ-031 rst asserted mid-payload -> outputs 0 immediately; a following MWr decodes correctly.
